// File: rtl/nt_pad_if.sv
// nt_pad_if: character-stream input and padded-block output of nt_pad.
// Carries ovf only when NT_PAD_OVERFLOW_FLAG_EN is defined.
interface nt_pad_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_char;
    logic         in_last;
    logic         in_null;
    logic         ordy;
    logic         ack;
    logic [511:0] data;
    logic [4:0]   nchars;
`ifdef NT_PAD_OVERFLOW_FLAG_EN
    logic         ovf;
    modport master (output in_valid, in_char, in_last, in_null, ack,
                    input in_ready, ordy, data, nchars, ovf);
    modport slave  (input in_valid, in_char, in_last, in_null, ack,
                    output in_ready, ordy, data, nchars, ovf);
`else
    modport master (output in_valid, in_char, in_last, in_null, ack,
                    input in_ready, ordy, data, nchars);
    modport slave  (input in_valid, in_char, in_last, in_null, ack,
                    output in_ready, ordy, data, nchars);
`endif
endinterface

// File: rtl/nt_pad.sv
// nt_pad: Latin-1 password stream to UTF-16LE, MD4-padded 512-bit block.
// NT_PAD_OVERFLOW_FLAG_EN: overlong passwords are truncated and flagged on ovf instead of dropped.
module nt_pad #(
    parameter int MAX_CHARS = 27
) (
    input logic   clk,
    input logic   rst,
    nt_pad_if.slave bus
);
`ifdef NT_PAD_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;
    state_t       state, next;
    logic [4:0]   cnt;
    logic [4:0]   nchars_q;
    logic [511:0] data_q;
    logic         accept, wr, over, drain_end, fin, clr;
    logic [4:0]   n_fin;
    logic [15:0]  len;
    logic [8:0]   wpos, tpos;

    assign accept    = bus.in_valid && bus.in_ready;
    assign wr        = accept && state == FILL && !bus.in_null && cnt < 5'(MAX_CHARS);
    assign over      = accept && state == FILL && !bus.in_null && cnt == 5'(MAX_CHARS);
    assign drain_end = accept && bus.in_last && (state == DRAIN || over);
    assign n_fin     = cnt + {4'b0, wr};
    assign len       = {7'b0, n_fin, 4'b0};
    assign wpos      = 9'(511 - 16 * int'(cnt));
    assign tpos      = 9'(511 - 16 * int'(n_fin));
    assign fin       = state != DONE && next == DONE;
    // A dropped overlong password must leave no residue for the next one
    assign clr       = (state == DONE && bus.ack) || (!OVF_EN && drain_end);

    assign bus.in_ready = state != DONE;
    assign bus.ordy     = state == DONE;
    assign bus.data     = data_q;
    assign bus.nchars   = nchars_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            FILL:    next = drain_end ? (OVF_EN ? DONE : FILL) :
                            over ? DRAIN :
                            (accept && bus.in_last) ? DONE : FILL;
            DRAIN:   next = drain_end ? (OVF_EN ? DONE : FILL) : DRAIN;
            DONE:    next = bus.ack ? FILL : DONE;
            default: next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            cnt      <= '0;
            nchars_q <= '0;
        end else if (clr) begin
            data_q   <= '0;
            cnt      <= '0;
            nchars_q <= '0;
        end else begin
            if (wr) begin
                data_q[wpos -: 16] <= {bus.in_char, 8'h00};
                cnt                <= cnt + 5'd1;
            end
            if (fin) begin
                data_q[tpos -: 8] <= 8'h80;
                data_q[63:48]     <= {len[7:0], len[15:8]};
                nchars_q          <= n_fin;
            end
        end
    end

`ifdef NT_PAD_OVERFLOW_FLAG_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ovf_q <= 1'b0;
        else if (state == DONE && bus.ack) ovf_q <= 1'b0;
        else if (drain_end)                ovf_q <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_nt_pad.sv
// tb_nt_pad: scoreboard bench for nt_pad; expected blocks are queued as passwords are sent.
module tb_nt_pad;
    typedef logic [7:0] q8_t[$];
    typedef struct {
        logic [511:0] d;
        logic [4:0]   n;
    } exp_t;

    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
    localparam logic [511:0] TEST_BLK  = {64'h7400650073007400, 8'h80, 376'h0, 8'h40, 56'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    nt_pad_if bus ();
    nt_pad #(.MAX_CHARS(27)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [511:0] model(input q8_t s);
        logic [7:0]   m[64];
        logic [15:0]  len;
        logic [511:0] r;
        int n;
        n = s.size() > 27 ? 27 : s.size();
        foreach (m[i]) m[i] = 8'h00;
        for (int i = 0; i < n; i++) m[2*i] = s[i];
        m[2*n] = 8'h80;
        len = 16'(n * 16);
        m[56] = len[7:0];
        m[57] = len[15:8];
        r = '0;
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = m[i];
        return r;
    endfunction

    function automatic q8_t word_test();
        q8_t q;
        q = {8'h74, 8'h65, 8'h73, 8'h74};
        return q;
    endfunction

    function automatic q8_t repeat_a(input int n);
        q8_t q;
        for (int i = 0; i < n; i++) q.push_back(8'h61);
        return q;
    endfunction

    task automatic send(input q8_t s);
        if (s.size() == 0) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_null = 1'b1; bus.in_last = 1'b1;
        end else begin
            foreach (s[i]) begin
                @(negedge clk);
                bus.in_valid = 1'b1; bus.in_null = 1'b0;
                bus.in_char  = s[i];
                bus.in_last  = (i == s.size() - 1);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_null = 1'b0;
    endtask

    task automatic wait_ordy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ordy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_block();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_char = 8'h00; bus.in_last = 1'b0;
        bus.in_null = 1'b0; bus.ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        tests++; if (bus.ordy !== 1'b0) begin fails++; $display("FAIL reset_ordy got %b exp 0", bus.ordy); end
        tests++; if (bus.data !== 512'h0) begin fails++; $display("FAIL reset_data got %h exp 0", bus.data); end
        tests++; if (bus.nchars !== 5'd0) begin fails++; $display("FAIL reset_nchars got %0d exp 0", bus.nchars); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty();
        q8_t  q;
        exp_t e;
        bit   ok;
        sb.push_back('{EMPTY_BLK, 5'd0});
        send(q);
        tests++; if (bus.ordy !== 1'b1) begin fails++; $display("FAIL empty_latency ordy got %b exp 1", bus.ordy); end
        wait_ordy(ok);
        e = sb.pop_front();
        tests++; if (!ok || bus.data !== e.d) begin fails++; $display("FAIL empty_data got %h exp %h", bus.data, e.d); end
        tests++; if (bus.nchars !== e.n) begin fails++; $display("FAIL empty_nchars got %0d exp %0d", bus.nchars, e.n); end
        ack_block();
        tests++; if (bus.ordy !== 1'b0) begin fails++; $display("FAIL ack_ordy got %b exp 0", bus.ordy); end
        tests++; if (bus.data !== 512'h0) begin fails++; $display("FAIL ack_data got %h exp 0", bus.data); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL ack_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_word();
        exp_t e;
        bit   ok;
        sb.push_back('{TEST_BLK, 5'd4});
        send(word_test());
        tests++; if (bus.ordy !== 1'b1) begin fails++; $display("FAIL test_latency ordy got %b exp 1", bus.ordy); end
        wait_ordy(ok);
        e = sb.pop_front();
        tests++; if (!ok || bus.data !== e.d) begin fails++; $display("FAIL test_data got %h exp %h", bus.data, e.d); end
        tests++; if (bus.nchars !== e.n) begin fails++; $display("FAIL test_nchars got %0d exp %0d", bus.nchars, e.n); end
        ack_block();
    endtask

    task automatic test_max();
        exp_t e;
        bit   ok;
        sb.push_back('{model(repeat_a(27)), 5'd27});
        send(repeat_a(27));
        wait_ordy(ok);
        e = sb.pop_front();
        tests++; if (!ok || bus.data !== e.d) begin fails++; $display("FAIL max_data got %h exp %h", bus.data, e.d); end
        tests++; if (bus.nchars !== e.n) begin fails++; $display("FAIL max_nchars got %0d exp %0d", bus.nchars, e.n); end
        tests++; if (bus.data[79:72] !== 8'h80) begin fails++; $display("FAIL max_byte54 got %h exp 80", bus.data[79:72]); end
        tests++; if (bus.data[71:64] !== 8'h00) begin fails++; $display("FAIL max_byte55 got %h exp 00", bus.data[71:64]); end
        tests++; if (bus.data[63:56] !== 8'hB0) begin fails++; $display("FAIL max_byte56 got %h exp b0", bus.data[63:56]); end
        tests++; if (bus.data[55:48] !== 8'h01) begin fails++; $display("FAIL max_byte57 got %h exp 01", bus.data[55:48]); end
        ack_block();
    endtask

    task automatic test_overflow(input int n);
        exp_t e;
        bit   ok;
`ifdef NT_PAD_OVERFLOW_FLAG_EN
        sb.push_back('{model(repeat_a(27)), 5'd27});
        send(repeat_a(n));
        wait_ordy(ok);
        e = sb.pop_front();
        tests++; if (!ok || bus.data !== e.d) begin fails++; $display("FAIL ovf_data len %0d got %h exp %h", n, bus.data, e.d); end
        tests++; if (bus.nchars !== e.n) begin fails++; $display("FAIL ovf_nchars got %0d exp %0d", bus.nchars, e.n); end
        tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", bus.ovf); end
        ack_block();
        tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", bus.ovf); end
`else
        send(repeat_a(n));
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.ordy !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL drop_len%0d ordy %b in_ready %b exp 0 1", n, bus.ordy, bus.in_ready); end
            @(negedge clk);
        end
        tests++; if (bus.data !== 512'h0) begin fails++; $display("FAIL drop_data got %h exp 0", bus.data); end
`endif
        sb.push_back('{TEST_BLK, 5'd4});
        send(word_test());
        wait_ordy(ok);
        e = sb.pop_front();
        tests++; if (!ok || bus.data !== e.d) begin fails++; $display("FAIL after_ovf_data got %h exp %h", bus.data, e.d); end
        tests++; if (bus.nchars !== e.n) begin fails++; $display("FAIL after_ovf_nchars got %0d exp %0d", bus.nchars, e.n); end
        ack_block();
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        sb.push_back('{TEST_BLK, 5'd4});
        send(word_test());
        wait_ordy(ok);
        e = sb.pop_front();
        bus.in_valid = 1'b1; bus.in_char = 8'h55; bus.in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (!ok || bus.in_ready !== 1'b0 || bus.data !== e.d) begin fails++; $display("FAIL hold_cycle%0d in_ready %b data %h exp 0 %h", i, bus.in_ready, bus.data, e.d); end
        end
        ack_block();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        tests++; if (bus.ordy !== 1'b0 || bus.data !== 512'h0) begin fails++; $display("FAIL ack_with_valid ordy %b data %h exp 0 0", bus.ordy, bus.data); end
        @(negedge clk);
        tests++; if (bus.ordy !== 1'b0 || bus.data !== 512'h0) begin fails++; $display("FAIL ack_char_taken ordy %b data %h exp 0 0", bus.ordy, bus.data); end
    endtask

    task automatic test_midreset();
        exp_t e;
        bit   ok;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_char = 8'h74; bus.in_last = 1'b0;
        @(negedge clk);
        bus.in_char = 8'h65;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.ordy !== 1'b0 || bus.data !== 512'h0) begin fails++; $display("FAIL midreset ordy %b data %h exp 0 0", bus.ordy, bus.data); end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{TEST_BLK, 5'd4});
        send(word_test());
        wait_ordy(ok);
        e = sb.pop_front();
        tests++; if (!ok || bus.data !== e.d) begin fails++; $display("FAIL post_reset_data got %h exp %h", bus.data, e.d); end
        tests++; if (bus.nchars !== e.n) begin fails++; $display("FAIL post_reset_nchars got %0d exp %0d", bus.nchars, e.n); end
        ack_block();
    endtask

    task automatic test_random();
        q8_t  q;
        exp_t e;
        bit   ok;
        for (int t = 0; t < 6; t++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 27)); i++) q.push_back(8'($urandom_range(32, 255)));
            sb.push_back('{model(q), 5'(q.size())});
            send(q);
            wait_ordy(ok);
            e = sb.pop_front();
            tests++; if (!ok || bus.data !== e.d || bus.nchars !== e.n) begin fails++; $display("FAIL random%0d nchars %0d data %h exp %0d %h", t, bus.nchars, bus.data, e.n, e.d); end
            ack_block();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_empty();
        test_word();
        test_max();
        test_overflow(28);
        test_overflow(30);
        test_hold();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
